mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter data_width, default 16, RAM word width in bits.
REQ-002 Parameter addr_width, default 8, RAM address width in bits.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 req0 / req1  in  1  access request from requester 0 (CPU) / requester 1 (IO).
REQ-006 we0 / we1  in  1  request is a write (1) or read (0).
REQ-007 addr0 / addr1  in  addr_width  request address.
REQ-008 wdata0 / wdata1  in  data_width  write data.
REQ-009 gnt0 / gnt1  out  1  one-cycle pulse: request accepted; requester may drop or change req after it.
REQ-010 rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds read result for that requester.
REQ-011 rdata  out  data_width  read result, shared by both requesters.
REQ-012 ram_read_address / ram_write_address  out  addr_width  to RAM.
REQ-013 ram_write  out  1  RAM write enable.
REQ-014 ram_din  out  data_width  RAM write data.
REQ-015 ram_dout  in  data_width  RAM read data, valid one clk cycle after ram_read_address is presented.

Function
REQ-016 FSM states: IDLE, ACCESS, RDATA; all outputs are driven from registered state and latched command only.
REQ-017 IDLE: no req -> stay IDLE; any req -> latch winner id, we, addr, wdata; go ACCESS.
REQ-018 Arbitration round-robin: sole requester wins; both requesting -> the one not served last wins.
REQ-019 ACCESS: ram_read_address = ram_write_address = latched addr; ram_write = latched we; ram_din = latched wdata; gnt of winner = 1.
REQ-020 ACCESS with we=1 -> IDLE (write = 2 cycles req-to-done); with we=0 -> RDATA.
REQ-021 RDATA: rdata = ram_dout, rvalid of winner = 1 for exactly one cycle; -> IDLE (read = 3 cycles req-to-rvalid).
REQ-022 ram_write SHALL be 0 in every state other than ACCESS with latched we=1.
REQ-023 gnt0/gnt1 never both 1; rvalid0/rvalid1 never both 1; gnt and rvalid never in same cycle.
REQ-024 Requests are not sampled in ACCESS or RDATA; a req held through them is arbitrated on return to IDLE.
REQ-025 Requester SHALL hold req/we/addr/wdata stable until its gnt; changes before gnt take effect only if sampled in IDLE.
REQ-026 Last-served pointer updates on entry to ACCESS; back-to-back contention alternates 0,1,0,1.
REQ-027 rdata holds its value outside RDATA (no zeroing required, but deterministic after reset).

Reset
REQ-028 reset -> state IDLE, gnt0=gnt1=0, rvalid0=rvalid1=0, ram_write=0, rdata=0, RAM address/data outputs 0, last-served = 1 (requester 0 wins first tie).
REQ-029 reset asserted in ACCESS or RDATA aborts the transaction: no gnt/rvalid in following cycle; a write in ACCESS coincident with reset SHALL NOT reach RAM (ram_write forced 0 same cycle).

Structure
REQ-030 Shared package holds FSM state encoding (2-bit: IDLE=00, ACCESS=01, RDATA=10) and requester-id constants.
REQ-031 One sub-module rr_pick (combinational: req0, req1, last -> valid, winner) for arbitration; rest in mem_arbiter.

Verification
REQ-032 Reset, then req0 write addr 8'h05 data 16'hBEEF -> gnt0 next cycle with ram_write=1, addr 05; later read 05 by req1 -> rvalid1 with rdata=BEEF 3 cycles after req.
REQ-033 req0 and req1 both reads, asserted same cycle after reset -> gnt0 first, rvalid0, then gnt1, rvalid1; no overlap.
REQ-034 Both held continuously, writes 0x10/0x11 -> grants alternate 0,1,0,1 for 4 transactions; each write occupies 2 cycles.
REQ-035 reset asserted during RDATA of a read -> no rvalid, outputs at reset values, next req1 read served normally.
REQ-036 Random mixed traffic vs. reference memory model: every rvalid data matches last written value, ram_write never high outside ACCESS.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - FSM encoding and requester ids shared by the arbiter files
package mem_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'b00;
    localparam logic [1:0] ST_ACCESS = 2'b01;
    localparam logic [1:0] ST_RDATA  = 2'b10;

    localparam logic ID_CPU = 1'b0;
    localparam logic ID_IO  = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// rtl/mem_arbiter_rr_pick.sv - two-way round-robin pick, combinational
module rr_pick
    import mem_arbiter_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic valid,
    output logic winner
);

    always_comb begin
        valid  = req0 | req1;
        winner = ID_CPU;
        if (req0 && req1) begin
            // Tie goes to whoever was not served last.
            winner = (last == ID_CPU) ? ID_IO : ID_CPU;
        end else if (req1) begin
            winner = ID_IO;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester single-port RAM arbiter (IDLE/ACCESS/RDATA)
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int data_width = 16,
    parameter int addr_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [addr_width-1:0] addr0,
    input  logic [addr_width-1:0] addr1,
    input  logic [data_width-1:0] wdata0,
    input  logic [data_width-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [data_width-1:0] rdata,
    output logic [addr_width-1:0] ram_read_address,
    output logic [addr_width-1:0] ram_write_address,
    output logic                  ram_write,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout
);

    logic [1:0]            state_q, state_d;
    logic                  id_q, id_d;
    logic                  we_q, we_d;
    logic                  last_q, last_d;
    logic [addr_width-1:0] addr_q, addr_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic [data_width-1:0] rdata_q, rdata_d;
    logic                  pick_valid;
    logic                  pick_winner;
    logic                  in_access;
    logic                  in_rdata;

    rr_pick u_rr_pick (
        .req0   (req0),
        .req1   (req1),
        .last   (last_q),
        .valid  (pick_valid),
        .winner (pick_winner)
    );

    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        we_d    = we_q;
        last_d  = last_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    id_d    = pick_winner;
                    last_d  = pick_winner;
                    we_d    = (pick_winner == ID_IO) ? we1    : we0;
                    addr_d  = (pick_winner == ID_IO) ? addr1  : addr0;
                    wdata_d = (pick_winner == ID_IO) ? wdata1 : wdata0;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                state_d = we_q ? ST_IDLE : ST_RDATA;
            end
            ST_RDATA: begin
                rdata_d = ram_dout;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            id_q    <= ID_CPU;
            we_q    <= 1'b0;
            last_q  <= ID_IO;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            we_q    <= we_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    // Reset masks strobes in the same cycle so an aborted write never reaches the RAM.
    assign in_access = (state_q == ST_ACCESS) && !reset;
    assign in_rdata  = (state_q == ST_RDATA) && !reset;

    assign gnt0    = in_access && (id_q == ID_CPU);
    assign gnt1    = in_access && (id_q == ID_IO);
    assign rvalid0 = in_rdata && (id_q == ID_CPU);
    assign rvalid1 = in_rdata && (id_q == ID_IO);

    assign ram_write         = in_access && we_q;
    assign ram_read_address  = addr_q;
    assign ram_write_address = addr_q;
    assign ram_din           = wdata_q;

    assign rdata = reset ? '0 : (in_rdata ? ram_dout : rdata_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a behavioural RAM
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [7:0]  addr0 = '0, addr1 = '0;
    logic [15:0] wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, rvalid0, rvalid1, ram_write;
    logic [15:0] rdata, ram_din, ram_dout;
    logic [7:0]  ram_read_address, ram_write_address;

    typedef struct {
        bit          id;
        logic [15:0] data;
    } exp_t;

    exp_t        exp_q[$];
    bit          gnt_log[$];
    int          gnt_cyc[$];
    logic [15:0] ram     [0:255];
    logic [15:0] ref_mem [0:255];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    bit          mon_en = 1'b0;

    mem_arbiter #(.data_width(16), .addr_width(8)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata),
        .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
        .ram_write(ram_write), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ram_write) ram[ram_write_address] <= ram_din;
        ram_dout <= ram[ram_read_address];
    end

    // Protocol invariants every cycle, plus scoreboard pop on each read return.
    always @(negedge clk) begin
        if (mon_en) begin
            total++;
            if ((gnt0 && gnt1) || (rvalid0 && rvalid1) || ((gnt0 || gnt1) && (rvalid0 || rvalid1))
                || (ram_write && !(gnt0 || gnt1))) begin
                bad++;
                $display("FAIL invariant got gnt=%b%b rvalid=%b%b ram_write=%b want exclusive strobes",
                         gnt1, gnt0, rvalid1, rvalid0, ram_write);
            end
            if (rvalid0 || rvalid1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rvalid_unexpected got rvalid=%b%b want none", rvalid1, rvalid0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (rvalid1 !== e.id || rdata !== e.data) begin
                        bad++;
                        $display("FAIL rdata got id=%0d data=%h want id=%0d data=%h",
                                 rvalid1, rdata, e.id, e.data);
                    end
                end
            end
        end
    end

    task automatic set_req(input bit id, input bit on, input bit w, input logic [7:0] a,
                           input logic [15:0] d);
        if (id == 1'b0) begin
            req0 = on; we0 = w; addr0 = a; wdata0 = d;
        end else begin
            req1 = on; we1 = w; addr1 = a; wdata1 = d;
        end
    endtask

    task automatic drive_req(input bit id, input bit w, input logic [7:0] a, input logic [15:0] d);
        bit got = 1'b0;
        int n = 0;
        set_req(id, 1'b1, w, a, d);
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if ((id == 1'b0 && gnt0) || (id == 1'b1 && gnt1)) begin
                got = 1'b1;
                gnt_log.push_back(id);
                gnt_cyc.push_back(cyc);
                if (w) ref_mem[a] = d;
                else exp_q.push_back('{id: id, data: ref_mem[a]});
            end
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL gnt_timeout id=%0d got=0 want=1", id);
        end
        @(posedge clk);
        #1;
        set_req(id, 1'b0, 1'b0, 8'h00, 16'h0000);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain got pending=%0d want 0", exp_q.size());
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_write} !== 5'b0 || rdata !== 16'h0
            || ram_read_address !== 8'h0 || ram_write_address !== 8'h0 || ram_din !== 16'h0) begin
            bad++;
            $display("FAIL reset_state got strobes=%b rdata=%h ra=%h wa=%h din=%h want all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, ram_write}, rdata, ram_read_address,
                     ram_write_address, ram_din);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_write_read();
        @(posedge clk); #1;
        set_req(1'b0, 1'b1, 1'b1, 8'h05, 16'hBEEF);
        @(negedge clk);
        total++;
        if (gnt0 !== 1'b0 || ram_write !== 1'b0) begin
            bad++;
            $display("FAIL write_idle got gnt0=%b ram_write=%b want 0 0", gnt0, ram_write);
        end
        @(negedge clk);
        total++;
        if (gnt0 !== 1'b1 || ram_write !== 1'b1 || ram_write_address !== 8'h05 || ram_din !== 16'hBEEF) begin
            bad++;
            $display("FAIL write_access got gnt0=%b we=%b wa=%h din=%h want 1 1 05 beef",
                     gnt0, ram_write, ram_write_address, ram_din);
        end
        ref_mem[8'h05] = 16'hBEEF;
        @(posedge clk); #1;
        set_req(1'b0, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        total++;
        if (ram_write !== 1'b0 || gnt0 !== 1'b0) begin
            bad++;
            $display("FAIL write_done got gnt0=%b ram_write=%b want 0 0", gnt0, ram_write);
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000);
        exp_q.push_back('{id: 1'b1, data: 16'hBEEF});
        @(negedge clk);
        @(negedge clk);
        total++;
        if (gnt1 !== 1'b1 || ram_write !== 1'b0 || ram_read_address !== 8'h05) begin
            bad++;
            $display("FAIL read_access got gnt1=%b we=%b ra=%h want 1 0 05", gnt1, ram_write, ram_read_address);
        end
        @(posedge clk); #1;
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        total++;
        if (rvalid1 !== 1'b1 || rdata !== 16'hBEEF) begin
            bad++;
            $display("FAIL read_latency got rvalid1=%b rdata=%h want 1 beef", rvalid1, rdata);
        end
        wait_drain();
    endtask

    task automatic test_tie();
        pulse_reset();
        gnt_log.delete();
        gnt_cyc.delete();
        fork
            drive_req(1'b0, 1'b0, 8'h05, 16'h0000);
            drive_req(1'b1, 1'b0, 8'h20, 16'h0000);
        join
        wait_drain();
        total++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 1'b0 || gnt_log[1] !== 1'b1
            || gnt_cyc[1] - gnt_cyc[0] != 3) begin
            bad++;
            $display("FAIL tie_order got n=%0d first=%0d gap=%0d want 2 0 3", gnt_log.size(),
                     gnt_log.size() > 0 ? gnt_log[0] : 1'b1,
                     gnt_log.size() > 1 ? gnt_cyc[1] - gnt_cyc[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        gnt_log.delete();
        gnt_cyc.delete();
        fork
            begin
                drive_req(1'b0, 1'b1, 8'h10, 16'h1000);
                drive_req(1'b0, 1'b1, 8'h10, 16'h1001);
            end
            begin
                drive_req(1'b1, 1'b1, 8'h11, 16'h2000);
                drive_req(1'b1, 1'b1, 8'h11, 16'h2001);
            end
        join
        for (int i = 0; i < 4; i++) begin
            total++;
            if (gnt_log.size() != 4 || gnt_log[i] !== i[0]
                || (i > 0 && gnt_cyc[i] - gnt_cyc[i-1] != 2)) begin
                bad++;
                $display("FAIL alternate[%0d] got id=%0d gap=%0d want id=%0d gap=2", i,
                         gnt_log.size() > i ? gnt_log[i] : 1'bx,
                         (i > 0 && gnt_log.size() > i) ? gnt_cyc[i] - gnt_cyc[i-1] : 2, i[0]);
            end
        end
        drive_req(1'b1, 1'b0, 8'h10, 16'h0000);
        drive_req(1'b0, 1'b0, 8'h11, 16'h0000);
        wait_drain();
    endtask

    task automatic test_reset_rdata();
        bit got = 1'b0;
        @(posedge clk); #1;
        set_req(1'b1, 1'b1, 1'b0, 8'h05, 16'h0000);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (gnt1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL abort_gnt got=0 want=1");
        end
        @(posedge clk); #1;
        reset = 1'b1;
        set_req(1'b1, 1'b0, 1'b0, 8'h00, 16'h0000);
        @(negedge clk);
        total++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata !== 16'h0 || ram_write !== 1'b0) begin
            bad++;
            $display("FAIL abort_rdata got rvalid=%b%b rdata=%h we=%b want 00 0000 0",
                     rvalid1, rvalid0, rdata, ram_write);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        total++;
        if ({gnt0, gnt1, rvalid0, rvalid1, ram_write} !== 5'b0 || rdata !== 16'h0
            || ram_read_address !== 8'h0 || ram_din !== 16'h0) begin
            bad++;
            $display("FAIL abort_after got strobes=%b rdata=%h ra=%h din=%h want all 0",
                     {gnt0, gnt1, rvalid0, rvalid1, ram_write}, rdata, ram_read_address, ram_din);
        end
        drive_req(1'b1, 1'b0, 8'h11, 16'h0000);
        wait_drain();
    endtask

    task automatic random_requester(input bit id);
        for (int i = 0; i < 25; i++) begin
            int gap;
            bit w;
            logic [7:0] a;
            logic [15:0] d;
            gap = $urandom_range(0, 3);
            w   = $urandom_range(0, 1);
            a   = 8'($urandom_range(0, 7));
            d   = 16'($urandom);
            repeat (gap) @(posedge clk);
            #1;
            drive_req(id, w, a, d);
        end
    endtask

    task automatic test_random();
        pulse_reset();
        fork
            random_requester(1'b0);
            random_requester(1'b1);
        join
        wait_drain();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            ram[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        test_reset();
        test_write_read();
        test_tie();
        test_back_to_back();
        test_reset_rdata();
        test_random();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

endmodule
